bram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-port, 32-bit block RAM between two requesters (e.g. CPU data port and a DMA/video fetch). It serialises requests, drives the BRAM select/write/mask/address/data lines, captures the BRAM's one-cycle registered read data, and returns it with a one-cycle acknowledge pulse. Out-of-range addresses are rejected with an error acknowledge and never reach the BRAM.

---
 rtl/bram_arbiter.sv | 159 +++++++++++++++
 tb/tb_bram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit BRAM between two requesters.
// Out-of-range word addresses are answered with an error ack and never reach the BRAM.
module bram_arbiter #(
    parameter int unsigned SIZE = 1024,
    parameter int unsigned AW   = $clog2(SIZE)
) (
    input  logic        clk,
    input  logic        reset_n_i,

    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_mask_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    output logic        p0_ack_o,
    output logic        p0_err_o,
    output logic [31:0] p0_rdata_o,

    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_mask_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p1_ack_o,
    output logic        p1_err_o,
    output logic [31:0] p1_rdata_o,

    output logic        bram_sel_o,
    output logic        bram_wr_en_o,
    output logic [3:0]  bram_wr_mask_o,
    output logic [31:0] bram_addr_o,
    output logic [31:0] bram_wdata_o,
    input  logic [31:0] bram_rdata_i
);

    localparam logic [31:0] LIMIT = 32'(SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;
    logic   we_q,    we_d;
    logic   err_q,   err_d;

    logic        elig0, elig1, any_elig, pick;
    logic        pick_we;
    logic [31:0] pick_addr;
    logic        pick_oor;

    logic [3:0]  g_mask;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;

    // The port being acknowledged this cycle is masked so the other port gets a turn.
    always_comb begin
        elig0    = p0_req_i && !(state_q == S_RESP && grant_q == 1'b0);
        elig1    = p1_req_i && !(state_q == S_RESP && grant_q == 1'b1);
        any_elig = elig0 || elig1;
        if (elig0 && elig1) begin
            pick = ~last_q;
        end else if (elig0) begin
            pick = 1'b0;
        end else begin
            pick = 1'b1;
        end
        pick_we   = pick ? p1_we_i   : p0_we_i;
        pick_addr = pick ? p1_addr_i : p0_addr_i;
        pick_oor  = (pick_addr >= LIMIT);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (any_elig) begin
                    grant_d = pick;
                    last_d  = pick;
                    we_d    = pick_we;
                    err_d   = pick_oor;
                    state_d = pick_oor ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        g_mask  = grant_q ? p1_mask_i  : p0_mask_i;
        g_addr  = grant_q ? p1_addr_i  : p0_addr_i;
        g_wdata = grant_q ? p1_wdata_i : p0_wdata_i;
    end

    always_comb begin
        bram_sel_o     = 1'b0;
        bram_wr_en_o   = 1'b0;
        bram_wr_mask_o = '0;
        bram_addr_o    = '0;
        bram_wdata_o   = '0;
        if (state_q == S_ACCESS) begin
            bram_sel_o     = 1'b1;
            bram_wr_en_o   = we_q;
            bram_wr_mask_o = we_q ? g_mask : 4'b0000;
            bram_addr_o    = 32'(g_addr[AW-1:0]);
            bram_wdata_o   = g_wdata;
        end
    end

    always_comb begin
        p0_ack_o   = 1'b0;
        p0_err_o   = 1'b0;
        p0_rdata_o = '0;
        p1_ack_o   = 1'b0;
        p1_err_o   = 1'b0;
        p1_rdata_o = '0;
        if (state_q == S_RESP) begin
            if (grant_q == 1'b0) begin
                p0_ack_o   = 1'b1;
                p0_err_o   = err_q;
                p0_rdata_o = (!we_q && !err_q) ? bram_rdata_i : '0;
            end else begin
                p1_ack_o   = 1'b1;
                p1_err_o   = err_q;
                p1_rdata_o = (!we_q && !err_q) ? bram_rdata_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural one-cycle-latency BRAM.
// Each slot is 1 time unit after a rising edge: outputs are checked first, then inputs are driven.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [3:0]  p0_mask_i, p1_mask_i;
    logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic        p0_ack_o, p0_err_o, p1_ack_o, p1_err_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        bram_sel_o, bram_wr_en_o;
    logic [3:0]  bram_wr_mask_o;
    logic [31:0] bram_addr_o, bram_wdata_o;
    logic [31:0] bram_rdata_i = '0;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.SIZE(1024)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_mask_i(p0_mask_i),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
        .p0_ack_o(p0_ack_o), .p0_err_o(p0_err_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_mask_i(p1_mask_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_ack_o(p1_ack_o), .p1_err_o(p1_err_o), .p1_rdata_o(p1_rdata_o),
        .bram_sel_o(bram_sel_o), .bram_wr_en_o(bram_wr_en_o),
        .bram_wr_mask_o(bram_wr_mask_o), .bram_addr_o(bram_addr_o),
        .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i)
    );

    always @(posedge clk) begin
        if (bram_sel_o) begin
            bram_rdata_i <= mem[bram_addr_o[9:0]];
            if (bram_wr_en_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bram_wr_mask_o[b]) mem[bram_addr_o[9:0]][8*b +: 8] = bram_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports;
        p0_req_i = 1'b0; p0_we_i = 1'b0; p0_mask_i = '0; p0_addr_i = '0; p0_wdata_i = '0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_mask_i = '0; p1_addr_i = '0; p1_wdata_i = '0;
    endtask

    task automatic test_reset;
        logic [137:0] all_out;
        idle_ports();
        reset_n_i = 1'b0;
        p0_req_i  = 1'b1;
        p0_addr_i = 32'd5;
        tick();
        tick();
        all_out = {p0_ack_o, p0_err_o, p0_rdata_o, p1_ack_o, p1_err_o, p1_rdata_o,
                   bram_sel_o, bram_wr_en_o, bram_wr_mask_o, bram_addr_o, bram_wdata_o};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        p0_req_i  = 1'b0;
        reset_n_i = 1'b1;
        tick();
        checks++;
        if ({p0_ack_o, bram_sel_o} !== 2'b00) begin
            errors++; $display("FAIL reset_idle got %b exp 00", {p0_ack_o, bram_sel_o});
        end
    endtask

    task automatic test_single_read;
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'd5; p0_mask_i = 4'hF;
        tick();
        checks++;
        if ({bram_sel_o, bram_wr_en_o, bram_wr_mask_o, bram_addr_o, p0_ack_o} !== {1'b1, 1'b0, 4'h0, 32'd5, 1'b0}) begin
            errors++; $display("FAIL read_access got sel=%b we=%b mask=%h addr=%h ack=%b exp 1 0 0 5 0",
                               bram_sel_o, bram_wr_en_o, bram_wr_mask_o, bram_addr_o, p0_ack_o);
        end
        tick();
        checks++;
        if ({p0_ack_o, p0_err_o, p0_rdata_o, p1_ack_o, bram_sel_o} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL read_resp got ack=%b err=%b rdata=%h p1ack=%b sel=%b exp 1 0 deadbeef 0 0",
                               p0_ack_o, p0_err_o, p0_rdata_o, p1_ack_o, bram_sel_o);
        end
        p0_req_i = 1'b0;
        tick();
        checks++;
        if ({p0_ack_o, bram_sel_o, p0_rdata_o} !== '0) begin
            errors++; $display("FAIL read_after got ack=%b sel=%b rdata=%h exp 0", p0_ack_o, bram_sel_o, p0_rdata_o);
        end
    endtask

    task automatic test_byte_write;
        p1_req_i = 1'b1; p1_we_i = 1'b1; p1_addr_i = 32'd3; p1_wdata_i = 32'h11223344; p1_mask_i = 4'b0101;
        tick();
        checks++;
        if ({bram_sel_o, bram_wr_en_o, bram_wr_mask_o, bram_addr_o, bram_wdata_o} !== {1'b1, 1'b1, 4'b0101, 32'd3, 32'h11223344}) begin
            errors++; $display("FAIL write_access got sel=%b we=%b mask=%b addr=%h wdata=%h exp 1 1 0101 3 11223344",
                               bram_sel_o, bram_wr_en_o, bram_wr_mask_o, bram_addr_o, bram_wdata_o);
        end
        tick();
        checks++;
        if ({p1_ack_o, p1_err_o, p1_rdata_o, p0_ack_o} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL write_resp got ack=%b err=%b rdata=%h p0ack=%b exp 1 0 0 0",
                               p1_ack_o, p1_err_o, p1_rdata_o, p0_ack_o);
        end
        p1_req_i = 1'b0;
        tick();
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_mask_i = 4'hF;
        tick();
        checks++;
        if ({bram_sel_o, bram_wr_en_o, bram_wr_mask_o} !== {1'b1, 1'b0, 4'h0}) begin
            errors++; $display("FAIL readback_access got sel=%b we=%b mask=%b exp 1 0 0000",
                               bram_sel_o, bram_wr_en_o, bram_wr_mask_o);
        end
        tick();
        checks++;
        if ({p1_ack_o, p1_rdata_o} !== {1'b1, 32'hAA22CC44}) begin
            errors++; $display("FAIL readback_data got ack=%b rdata=%h exp 1 aa22cc44", p1_ack_o, p1_rdata_o);
        end
        p1_req_i = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        logic exp_a0, exp_a1, exp_sel;
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'd10;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'd20;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_a0  = (k % 4 == 2);
            exp_a1  = (k % 4 == 0);
            exp_sel = (k % 2 == 1);
            checks++;
            if ({p0_ack_o, p1_ack_o, bram_sel_o} !== {exp_a0, exp_a1, exp_sel}) begin
                errors++; $display("FAIL contention_seq k=%0d got a0=%b a1=%b sel=%b exp %b %b %b",
                                   k, p0_ack_o, p1_ack_o, bram_sel_o, exp_a0, exp_a1, exp_sel);
            end
            if (k % 4 == 1 || k % 4 == 3) begin
                checks++;
                if (bram_addr_o !== ((k % 4 == 1) ? 32'd10 : 32'd20)) begin
                    errors++; $display("FAIL contention_addr k=%0d got %h", k, bram_addr_o);
                end
            end
            if (exp_a0) begin
                checks++;
                if (p0_rdata_o !== 32'h0A0A0A0A) begin
                    errors++; $display("FAIL contention_p0_data got %h exp 0a0a0a0a", p0_rdata_o);
                end
            end
            if (exp_a1) begin
                checks++;
                if (p1_rdata_o !== 32'h1B1B1B1B) begin
                    errors++; $display("FAIL contention_p1_data got %h exp 1b1b1b1b", p1_rdata_o);
                end
            end
        end
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
        tick();
        checks++;
        if ({p0_ack_o, p1_ack_o, bram_sel_o} !== 3'b000) begin
            errors++; $display("FAIL contention_drain got %b exp 000", {p0_ack_o, p1_ack_o, bram_sel_o});
        end
    endtask

    task automatic test_streaming;
        logic exp_ack, exp_sel;
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'd40;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_ack = (k % 3 == 2);
            exp_sel = (k % 3 == 1);
            checks++;
            if ({p0_ack_o, bram_sel_o} !== {exp_ack, exp_sel}) begin
                errors++; $display("FAIL stream_seq k=%0d got ack=%b sel=%b exp %b %b",
                                   k, p0_ack_o, bram_sel_o, exp_ack, exp_sel);
            end
            if (exp_ack) begin
                checks++;
                if (p0_rdata_o !== 32'h100 + 32'((k - 2) / 3)) begin
                    errors++; $display("FAIL stream_data k=%0d got %h exp %h", k, p0_rdata_o, 32'h100 + 32'((k - 2) / 3));
                end
                p0_addr_i = p0_addr_i + 32'd1;
            end
        end
        p0_req_i = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'd1024;
        tick();
        checks++;
        if ({p1_ack_o, p1_err_o, p1_rdata_o, bram_sel_o, p0_ack_o} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL oor_resp got ack=%b err=%b rdata=%h sel=%b p0ack=%b exp 1 1 0 0 0",
                               p1_ack_o, p1_err_o, p1_rdata_o, bram_sel_o, p0_ack_o);
        end
        p1_req_i = 1'b0;
        tick();
        checks++;
        if ({p1_ack_o, p1_err_o, bram_sel_o} !== 3'b000) begin
            errors++; $display("FAIL oor_after got %b exp 000", {p1_ack_o, p1_err_o, bram_sel_o});
        end
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'd1023;
        tick();
        checks++;
        if ({bram_sel_o, bram_addr_o} !== {1'b1, 32'd1023}) begin
            errors++; $display("FAIL top_word_access got sel=%b addr=%h exp 1 3ff", bram_sel_o, bram_addr_o);
        end
        tick();
        checks++;
        if ({p0_ack_o, p0_err_o, p0_rdata_o} !== {1'b1, 1'b0, 32'h5A5A1234}) begin
            errors++; $display("FAIL top_word_resp got ack=%b err=%b rdata=%h exp 1 0 5a5a1234",
                               p0_ack_o, p0_err_o, p0_rdata_o);
        end
        p0_req_i = 1'b1; p0_we_i = 1'b1; p0_addr_i = 32'h8000_0005; p0_wdata_i = 32'h0; p0_mask_i = 4'hF;
        tick();
        checks++;
        if ({p0_ack_o, bram_sel_o} !== 2'b00) begin
            errors++; $display("FAIL oor_write_gap got %b exp 00", {p0_ack_o, bram_sel_o});
        end
        tick();
        checks++;
        if ({p0_ack_o, p0_err_o, bram_sel_o, bram_wr_en_o} !== 4'b1100) begin
            errors++; $display("FAIL oor_write_resp got %b exp 1100", {p0_ack_o, p0_err_o, bram_sel_o, bram_wr_en_o});
        end
        p0_req_i = 1'b0; p0_we_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_access;
        logic [137:0] all_out;
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 32'd5;
        tick();
        checks++;
        if (bram_sel_o !== 1'b1) begin
            errors++; $display("FAIL rst_access_sel got %b exp 1", bram_sel_o);
        end
        reset_n_i = 1'b0;
        #1;
        all_out = {p0_ack_o, p0_err_o, p0_rdata_o, p1_ack_o, p1_err_o, p1_rdata_o,
                   bram_sel_o, bram_wr_en_o, bram_wr_mask_o, bram_addr_o, bram_wdata_o};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_async_clear got %h exp 0", all_out);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({p0_ack_o, bram_sel_o} !== 2'b00) begin
                errors++; $display("FAIL rst_held k=%0d got %b exp 00", k, {p0_ack_o, bram_sel_o});
            end
        end
        reset_n_i = 1'b1;
        tick();
        checks++;
        if ({bram_sel_o, bram_addr_o, p0_ack_o} !== {1'b1, 32'd5, 1'b0}) begin
            errors++; $display("FAIL rst_release_access got sel=%b addr=%h ack=%b exp 1 5 0",
                               bram_sel_o, bram_addr_o, p0_ack_o);
        end
        tick();
        checks++;
        if ({p0_ack_o, p0_err_o, p0_rdata_o} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rst_release_resp got ack=%b err=%b rdata=%h exp 1 0 deadbeef",
                               p0_ack_o, p0_err_o, p0_rdata_o);
        end
        p0_req_i = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF0000 | 32'(i);
        mem[5]    = 32'hDEADBEEF;
        mem[3]    = 32'hAABBCCDD;
        mem[10]   = 32'h0A0A0A0A;
        mem[20]   = 32'h1B1B1B1B;
        mem[1023] = 32'h5A5A1234;
        for (int i = 0; i < 4; i++) mem[40 + i] = 32'h100 + 32'(i);

        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_streaming();
        test_out_of_range();
        test_reset_in_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
